// File: rtl/bster_gen_pkg.sv
// rtl/bster_gen_pkg.sv - shared types, field layout and LFSR polynomial for the bster traffic generator
package bster_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_INSERT   = 3'd1,
        ST_SEARCH   = 3'd2,
        ST_WAIT_CPL = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        MODE_INTERLEAVED = 2'd0,
        MODE_BATCH       = 2'd1,
        MODE_MISS        = 2'd2,
        MODE_RSVD        = 2'd3
    } mode_t;

    // Opcodes understood by the bster engine
    localparam logic [3:0] INSERT_TOKEN = 4'h1;
    localparam logic [3:0] SEARCH_TOKEN = 4'h2;

    // Command word layout: payload at bit 0, token above it, opcode above the token
    localparam int PAYLOAD_LSB  = 0;
    localparam int OPCODE_WIDTH = 4;

    function automatic int token_lsb(int payload_width);
        return payload_width;
    endfunction

    function automatic int opcode_lsb(int payload_width, int token_width);
        return payload_width + token_width;
    endfunction

    // Right-shift Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

    function automatic logic [31:0] lfsr_next(logic [31:0] s);
        return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
    endfunction

endpackage

// File: rtl/bster_lfsr.sv
// rtl/bster_lfsr.sv - 32-bit Galois LFSR payload source with load and step controls
module bster_lfsr
    import bster_gen_pkg::*;
(
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        load,
    input  logic        step,
    input  logic [31:0] seed,
    output logic [31:0] state
);

    // Load wins over step; an all-zero seed would lock up the register, so it becomes 1
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= '0;
        end else if (load) begin
            state <= (seed == 32'd0) ? 32'd1 : seed;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/bster_traffic_gen.sv
// rtl/bster_traffic_gen.sv - insert/search command generator with completion checking
module bster_traffic_gen
    import bster_gen_pkg::*;
#(
    parameter int TOKEN_WIDTH   = 8,
    parameter int PAYLOAD_WIDTH = 32,
    parameter int AXI4S_WIDTH   = 128,
    parameter int CNT_WIDTH     = 16,
    parameter int TIMEOUT       = 1024
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [TOKEN_WIDTH-1:0]   base_token,
    input  logic [TOKEN_WIDTH-1:0]   count,
    input  logic [31:0]              seed,
    output logic                     busy,
    output logic                     done,
    output logic                     pass,
    output logic [CNT_WIDTH-1:0]     err_cnt,
    output logic [CNT_WIDTH-1:0]     cpl_cnt,
    output logic                     cmd_tvalid,
    input  logic                     cmd_tready,
    output logic [AXI4S_WIDTH-1:0]   cmd_tdata,
    input  logic                     cpl_tvalid,
    output logic                     cpl_tready,
    input  logic [AXI4S_WIDTH-1:0]   cpl_tdata
);

    localparam int TOK_LSB = token_lsb(PAYLOAD_WIDTH);
    localparam int OP_LSB  = opcode_lsb(PAYLOAD_WIDTH, TOKEN_WIDTH);
    localparam int TMO_W   = $clog2(TIMEOUT + 1);

    state_t                   state_q, state_d;
    mode_t                    mode_q;
    logic [TOKEN_WIDTH-1:0]   base_q, count_q, idx_q, cur_token;
    logic [31:0]              seed_q, lfsr_seed, lfsr_state;
    logic [PAYLOAD_WIDTH-1:0] exp_q, lfsr_payload;
    logic [TMO_W-1:0]         tmo_q;
    logic                     pass_q;
    logic                     cmd_fire, cpl_fire, last_idx, tmo_hit, wait_end, check_bad;
    logic                     lfsr_load, lfsr_step;
    logic                     unused_cpl_bits;

    assign cmd_fire     = cmd_tvalid && cmd_tready;
    assign cpl_fire     = cpl_tvalid && cpl_tready;
    assign last_idx     = (idx_q == count_q - TOKEN_WIDTH'(1));
    assign cur_token    = base_q + idx_q;
    assign lfsr_payload = PAYLOAD_WIDTH'(lfsr_state);
    assign tmo_hit      = (state_q == ST_WAIT_CPL) && !cpl_fire && (tmo_q == TMO_W'(TIMEOUT - 1));
    assign wait_end     = (state_q == ST_WAIT_CPL) && (cpl_fire || tmo_hit);
    assign check_bad    = (mode_q == MODE_MISS)
                        ? !cpl_tdata[AXI4S_WIDTH-1]
                        : (cpl_tdata[AXI4S_WIDTH-1] || (cpl_tdata[PAYLOAD_WIDTH-1:0] != exp_q));
    assign unused_cpl_bits = ^cpl_tdata[AXI4S_WIDTH-2:PAYLOAD_WIDTH];

    // Seed from the port on start, from the latched copy when BATCH rewinds for its search pass
    assign lfsr_load = ((state_q == ST_IDLE) && start)
                     || ((state_q == ST_INSERT) && cmd_fire && (mode_q == MODE_BATCH) && last_idx);
    assign lfsr_seed = (state_q == ST_IDLE) ? seed : seed_q;
    assign lfsr_step = cmd_fire && ((state_q == ST_INSERT)
                     || ((state_q == ST_SEARCH) && (mode_q == MODE_BATCH)));

    bster_lfsr u_lfsr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .load    (lfsr_load),
        .step    (lfsr_step),
        .seed    (lfsr_seed),
        .state   (lfsr_state)
    );

    // State register
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Next-state sequencing for the three run modes
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (start) state_d = ((count == '0) || (mode == 2'd3)) ? ST_DONE : ST_INSERT;
            ST_INSERT: if (cmd_fire) begin
                if (mode_q == MODE_INTERLEAVED) state_d = ST_SEARCH;
                else if (last_idx)              state_d = ST_SEARCH;
            end
            ST_SEARCH: if (cmd_fire) state_d = ST_WAIT_CPL;
            ST_WAIT_CPL: if (wait_end) begin
                if (mode_q == MODE_INTERLEAVED) state_d = last_idx ? ST_DONE : ST_INSERT;
                else if (mode_q == MODE_BATCH)  state_d = last_idx ? ST_DONE : ST_SEARCH;
                else                            state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Run parameters, token index, expected payload, timeout and status counters
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            mode_q  <= MODE_INTERLEAVED;
            base_q  <= '0;
            count_q <= '0;
            seed_q  <= '0;
            idx_q   <= '0;
            exp_q   <= '0;
            tmo_q   <= '0;
            err_cnt <= '0;
            cpl_cnt <= '0;
            pass_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: if (start) begin
                    mode_q  <= mode_t'(mode);
                    base_q  <= base_token;
                    count_q <= count;
                    seed_q  <= seed;
                    idx_q   <= '0;
                    err_cnt <= (mode == 2'd3) ? CNT_WIDTH'(1) : '0;
                    cpl_cnt <= '0;
                end
                ST_INSERT: if (cmd_fire) begin
                    exp_q <= lfsr_payload;
                    if (mode_q != MODE_INTERLEAVED)
                        idx_q <= ((mode_q == MODE_BATCH) && last_idx) ? '0 : idx_q + TOKEN_WIDTH'(1);
                end
                ST_SEARCH: if (cmd_fire) begin
                    tmo_q <= '0;
                    if (mode_q == MODE_BATCH) exp_q <= lfsr_payload;
                end
                ST_WAIT_CPL: begin
                    if (wait_end) idx_q <= idx_q + TOKEN_WIDTH'(1);
                    else          tmo_q <= tmo_q + TMO_W'(1);
                    if (cpl_fire && !(&cpl_cnt)) cpl_cnt <= cpl_cnt + CNT_WIDTH'(1);
                    if (((cpl_fire && check_bad) || tmo_hit) && !(&err_cnt))
                        err_cnt <= err_cnt + CNT_WIDTH'(1);
                end
                ST_DONE: pass_q <= (err_cnt == '0);
                default: ;
            endcase
        end
    end

    // Stream handshakes, command word and status outputs decoded from the state
    always_comb begin
        cmd_tvalid = 1'b0;
        cmd_tdata  = '0;
        cpl_tready = (state_q == ST_WAIT_CPL);
        busy       = (state_q != ST_IDLE);
        done       = (state_q == ST_DONE);
        pass       = pass_q;
        case (state_q)
            ST_INSERT: begin
                cmd_tvalid = 1'b1;
                cmd_tdata[PAYLOAD_LSB +: PAYLOAD_WIDTH] = lfsr_payload;
                cmd_tdata[TOK_LSB +: TOKEN_WIDTH]       = cur_token;
                cmd_tdata[OP_LSB +: OPCODE_WIDTH]       = INSERT_TOKEN;
            end
            ST_SEARCH: begin
                cmd_tvalid = 1'b1;
                cmd_tdata[TOK_LSB +: TOKEN_WIDTH]       = cur_token;
                cmd_tdata[OP_LSB +: OPCODE_WIDTH]       = SEARCH_TOKEN;
            end
            ST_DONE: pass = (err_cnt == '0);
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bster_traffic_gen.sv
// tb/tb_bster_traffic_gen.sv - self-checking bench for bster_traffic_gen
module tb_bster_traffic_gen;
    import bster_gen_pkg::*;

    localparam int TW = 8, PW = 32, AW = 128, CW = 16, TMO = 16;
    localparam int F_NONE = 0, F_WRONG_STALL = 1, F_NEVER = 2;

    logic          aclk, aresetn, start;
    logic [1:0]    mode;
    logic [TW-1:0] base_token, count;
    logic [31:0]   seed;
    logic          busy, done, pass;
    logic [CW-1:0] err_cnt, cpl_cnt;
    logic          cmd_tvalid, cmd_tready, cpl_tvalid, cpl_tready;
    logic [AW-1:0] cmd_tdata, cpl_tdata;

    bster_traffic_gen #(.TOKEN_WIDTH(TW), .PAYLOAD_WIDTH(PW), .AXI4S_WIDTH(AW),
                        .CNT_WIDTH(CW), .TIMEOUT(TMO)) dut (
        .aclk(aclk), .aresetn(aresetn), .start(start), .mode(mode),
        .base_token(base_token), .count(count), .seed(seed),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt), .cpl_cnt(cpl_cnt),
        .cmd_tvalid(cmd_tvalid), .cmd_tready(cmd_tready), .cmd_tdata(cmd_tdata),
        .cpl_tvalid(cpl_tvalid), .cpl_tready(cpl_tready), .cpl_tdata(cpl_tdata)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int checks = 0, errors = 0;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Responder: token memory acting as the bster engine, plus fault injection
    logic [PW-1:0] mem [256];
    bit            vld [256];
    int            fault = F_NONE, cpl_num = 0, delay = 0, stall_cnt = 0;
    bit            pend = 0, stall_have = 0, stall_bad = 0, last_cpl_err = 0;
    logic [TW-1:0] pend_tok, r_tok;
    logic [AW-1:0] stall_word;
    logic [AW-1:0] got_q[$];

    initial begin
        logic [AW-1:0] w;
        logic [PW-1:0] pl;
        cmd_tready = 1'b0; cpl_tvalid = 1'b0; cpl_tdata = '0;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                pend = 0;
            end else begin
                if (stall_cnt > 0 && cmd_tvalid) begin
                    if (!stall_have) begin stall_word = cmd_tdata; stall_have = 1; end
                    else if (cmd_tdata !== stall_word) stall_bad = 1;
                end
                if (cmd_tvalid && cmd_tready) begin
                    got_q.push_back(cmd_tdata);
                    r_tok = cmd_tdata[PW +: TW];
                    if (cmd_tdata[PW+TW +: 4] == INSERT_TOKEN) begin
                        mem[r_tok] = cmd_tdata[PW-1:0];
                        vld[r_tok] = 1;
                    end else begin
                        pend = 1; pend_tok = r_tok; delay = $urandom_range(0, 4);
                    end
                    if (fault == F_WRONG_STALL && got_q.size() == 5) stall_cnt = 50;
                end
                if (cpl_tvalid && cpl_tready) begin
                    pend = 0; cpl_num++; last_cpl_err = cpl_tdata[AW-1];
                end
            end
            @(posedge aclk); #1;
            if (stall_cnt > 0) begin cmd_tready = 1'b0; stall_cnt--; end
            else cmd_tready = ($urandom_range(0, 3) != 0);
            if (pend && fault != F_NEVER && delay == 0) begin
                pl = vld[pend_tok] ? mem[pend_tok] : '0;
                if (fault == F_WRONG_STALL && cpl_num == 2) pl = pl ^ 32'h1;
                w = '0;
                w[AW-2 -: 8] = 8'hA5;
                w[PW-1:0] = pl;
                w[AW-1] = !vld[pend_tok];
                cpl_tvalid = 1'b1; cpl_tdata = w;
            end else begin
                if (pend && delay > 0) delay--;
                cpl_tvalid = 1'b0;
            end
        end
    end

    // Reference model: command list and final status derived from the run rules
    logic [AW-1:0] exp_q[$], exp_mask[$];

    function automatic logic [31:0] ref_step(logic [31:0] s);
        logic [31:0] taps;
        int ex [4];
        ex = '{32, 22, 2, 1};
        taps = '0;
        for (int k = 0; k < 4; k++) taps[ex[k]-1] = 1'b1;
        return s[0] ? ((s >> 1) ^ taps) : (s >> 1);
    endfunction

    function automatic logic [AW-1:0] mk(logic [3:0] op, logic [TW-1:0] tok, logic [PW-1:0] pl);
        logic [AW-1:0] w;
        w = '0; w[PW-1:0] = pl; w[PW +: TW] = tok; w[PW+TW +: 4] = op;
        return w;
    endfunction

    task automatic model(input logic [1:0] m, input logic [TW-1:0] b, input logic [TW-1:0] c,
                         input logic [31:0] s, input int f,
                         output logic [CW-1:0] e, output logic [CW-1:0] cp, output logic p);
        logic [31:0]   lf;
        logic [PW-1:0] pay[$];
        logic [AW-1:0] all1, nopay;
        int            ns;
        all1 = '1; nopay = all1; nopay[PW-1:0] = '0;
        exp_q.delete(); exp_mask.delete();
        lf = (s == 0) ? 32'd1 : s;
        for (int i = 0; i < int'(c); i++) begin pay.push_back(lf[PW-1:0]); lf = ref_step(lf); end
        ns = 0;
        if (m != 2'd3 && c != 0) begin
            if (m == 2'd0) begin
                for (int i = 0; i < int'(c); i++) begin
                    exp_q.push_back(mk(INSERT_TOKEN, b + TW'(i), pay[i])); exp_mask.push_back(all1);
                    exp_q.push_back(mk(SEARCH_TOKEN, b + TW'(i), '0));     exp_mask.push_back(nopay);
                end
                ns = int'(c);
            end else begin
                for (int i = 0; i < int'(c); i++) begin
                    exp_q.push_back(mk(INSERT_TOKEN, b + TW'(i), pay[i])); exp_mask.push_back(all1);
                end
                if (m == 2'd1) begin
                    for (int i = 0; i < int'(c); i++) begin
                        exp_q.push_back(mk(SEARCH_TOKEN, b + TW'(i), '0)); exp_mask.push_back(nopay);
                    end
                    ns = int'(c);
                end else begin
                    exp_q.push_back(mk(SEARCH_TOKEN, b + c, '0)); exp_mask.push_back(all1);
                    ns = 1;
                end
            end
        end
        e  = (m == 2'd3) ? CW'(1) : '0;
        cp = CW'(ns);
        if (f == F_WRONG_STALL && ns >= 3) e = e + CW'(1);
        if (f == F_NEVER) begin e = e + CW'(ns); cp = '0; end
        p = (e == 0);
    endtask

    task automatic run(input logic [1:0] m, input logic [TW-1:0] b, input logic [TW-1:0] c,
                       input logic [31:0] s, input int f, output int cycles,
                       output logic p_o, output logic [CW-1:0] e_o, output logic [CW-1:0] cpl_o);
        bit seen;
        fault = f; pend = 0; cpl_num = 0; stall_cnt = 0;
        stall_have = 0; stall_bad = 0; last_cpl_err = 0;
        for (int k = 0; k < 256; k++) vld[k] = 0;
        got_q.delete();
        @(posedge aclk); #1;
        start = 1'b1; mode = m; base_token = b; count = c; seed = s;
        @(posedge aclk); #1;
        start = 1'b0; mode = 2'd3; count = '0; base_token = ~b; seed = ~s;
        cycles = 0; seen = 0; p_o = 0; e_o = '0; cpl_o = '0;
        while (!seen && cycles < 5000) begin
            @(negedge aclk);
            if (cycles == 0) check("busy_after_start", busy, 1);
            if (done) begin
                seen = 1; p_o = pass; e_o = err_cnt; cpl_o = cpl_cnt;
            end else begin
                @(posedge aclk); #1;
                start = (cycles == 3);
                cycles++;
            end
        end
        check("done_seen", seen, 1);
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic check_stream();
        check("ncmd_vs_model", got_q.size(), exp_q.size());
        for (int k = 0; k < got_q.size() && k < exp_q.size(); k++)
            check("cmd_word", got_q[k] & exp_mask[k], exp_q[k] & exp_mask[k]);
    endtask

    typedef struct {
        logic [1:0]    m;
        logic [TW-1:0] b, c;
        logic [31:0]   s;
        int            f, ncmd;
        logic [CW-1:0] err, cpl;
        logic          p;
    } vec_t;

    vec_t tbl [8];

    initial begin
        logic [CW-1:0] e, cp, me, mcp;
        logic          p, mp;
        int            cyc;
        bit            seen, bad;
        logic [1:0]    rm;
        logic [TW-1:0] rb, rc;
        logic [31:0]   rs;

        tbl[0] = '{m:2'd0, b:8'h01, c:8'd8, s:32'h1,        f:F_NONE,        ncmd:16, err:16'd0, cpl:16'd8, p:1'b1};
        tbl[1] = '{m:2'd1, b:8'hFE, c:8'd4, s:32'h0000ACE1, f:F_NONE,        ncmd:8,  err:16'd0, cpl:16'd4, p:1'b1};
        tbl[2] = '{m:2'd2, b:8'h01, c:8'd8, s:32'h5,        f:F_NONE,        ncmd:9,  err:16'd0, cpl:16'd1, p:1'b1};
        tbl[3] = '{m:2'd0, b:8'h10, c:8'd8, s:32'h7,        f:F_WRONG_STALL, ncmd:16, err:16'd1, cpl:16'd8, p:1'b0};
        tbl[4] = '{m:2'd0, b:8'h03, c:8'd2, s:32'h9,        f:F_NEVER,       ncmd:4,  err:16'd2, cpl:16'd0, p:1'b0};
        tbl[5] = '{m:2'd0, b:8'h20, c:8'd0, s:32'h3,        f:F_NONE,        ncmd:0,  err:16'd0, cpl:16'd0, p:1'b1};
        tbl[6] = '{m:2'd3, b:8'h20, c:8'd5, s:32'h3,        f:F_NONE,        ncmd:0,  err:16'd1, cpl:16'd0, p:1'b0};
        tbl[7] = '{m:2'd1, b:8'h80, c:8'd3, s:32'h0,        f:F_NONE,        ncmd:6,  err:16'd0, cpl:16'd3, p:1'b1};

        aresetn = 1'b0; start = 1'b0; mode = '0; base_token = '0; count = '0; seed = '0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_busy", busy, 0);       check("rst_done", done, 0);
        check("rst_pass", pass, 0);       check("rst_err_cnt", err_cnt, 0);
        check("rst_cpl_cnt", cpl_cnt, 0); check("rst_cmd_tvalid", cmd_tvalid, 0);
        check("rst_cmd_tdata", cmd_tdata, 0); check("rst_cpl_tready", cpl_tready, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            model(tbl[i].m, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].f, me, mcp, mp);
            run(tbl[i].m, tbl[i].b, tbl[i].c, tbl[i].s, tbl[i].f, cyc, p, e, cp);
            check_stream();
            check("ncmd", got_q.size(), tbl[i].ncmd);
            check("err_cnt", e, tbl[i].err);
            check("cpl_cnt", cp, tbl[i].cpl);
            check("pass", p, tbl[i].p);
            check("pass_hold", pass, tbl[i].p);
            check("err_hold", err_cnt, tbl[i].err);
            if (tbl[i].f == F_WRONG_STALL) begin
                check("stall_seen", stall_have, 1);
                check("stall_stable", stall_bad, 0);
            end
            if (tbl[i].m == 2'd2) check("miss_err_flag", last_cpl_err, 1);
            if (tbl[i].f == F_NEVER) check("timeout_timing", (cyc >= 2*TMO) && (cyc < 2*TMO + 40), 1);
        end

        repeat (8) begin
            rm = 2'($urandom_range(0, 3));
            rb = 8'($urandom);
            rc = 8'($urandom_range(1, 12));
            rs = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            model(rm, rb, rc, rs, F_NONE, me, mcp, mp);
            run(rm, rb, rc, rs, F_NONE, cyc, p, e, cp);
            check_stream();
            check("rnd_err_cnt", e, me);
            check("rnd_cpl_cnt", cp, mcp);
            check("rnd_pass", p, mp);
        end

        fault = F_NONE; pend = 0;
        for (int k = 0; k < 256; k++) vld[k] = 0;
        got_q.delete();
        @(posedge aclk); #1;
        start = 1'b1; mode = 2'd1; base_token = 8'h40; count = 8'd6; seed = $urandom;
        @(posedge aclk); #1;
        start = 1'b0;
        seen = 0;
        for (int n = 0; n < 3000 && !seen; n++) begin
            @(negedge aclk);
            if (got_q.size() >= 7) seen = 1;
        end
        check("reached_search_phase", seen, 1);
        #2 aresetn = 1'b0;
        #1;
        check("arst_cmd_tvalid", cmd_tvalid, 0); check("arst_cmd_tdata", cmd_tdata, 0);
        check("arst_cpl_tready", cpl_tready, 0); check("arst_busy", busy, 0);
        check("arst_done", done, 0);             check("arst_pass", pass, 0);
        check("arst_err_cnt", err_cnt, 0);       check("arst_cpl_cnt", cpl_cnt, 0);
        @(posedge aclk); #1;
        aresetn = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge aclk);
            if (cmd_tvalid || busy) bad = 1;
        end
        check("no_cmd_after_reset", bad, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not reach its end, errors so far %0d", errors);
        $fatal(1);
    end

endmodule
